// File: rtl/snake_body_engine.sv
// Snake position store and move engine.
// Holds the head plus up to MAX_LENGTH-1 body segments. Each accepted game_tik
// computes a new head, shifts the body in one cycle, optionally grows, then
// walks the body one segment per cycle looking for self-collision.
module snake_body_engine #(
  parameter int COORD_BIT        = 7,
  parameter int SNAKE_LENGTH_BIT = 4,
  parameter int MAX_LENGTH       = 15,
  parameter int GRID_W           = 64,
  parameter int GRID_H           = 48,
  parameter int START_X          = 10,
  parameter int START_Y          = 10,
  parameter int START_LEN        = 3,
  parameter int WRAP             = 0
) (
  input  logic                        clock_25,
  input  logic                        reset,
  input  logic                        game_tik,
  input  logic [1:0]                  dir,
  input  logic                        grow,
  input  logic                        restart,
  input  logic [SNAKE_LENGTH_BIT-1:0] rd_index,
  output logic [COORD_BIT-1:0]        rd_x,
  output logic [COORD_BIT-1:0]        rd_y,
  output logic                        rd_valid,
  output logic [COORD_BIT-1:0]        snake_head_x,
  output logic [COORD_BIT-1:0]        snake_head_y,
  output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
  output logic                        busy,
  output logic                        move_done,
  output logic                        collision_detected
);

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, DONE, DEAD} state_t;

  localparam logic [1:0] RIGHT = 2'b00, LEFT = 2'b01, UP = 2'b10, DOWN = 2'b11;
  localparam logic signed [COORD_BIT:0] ONE  = 1;
  localparam logic signed [COORD_BIT:0] GW   = (COORD_BIT+1)'(GRID_W);
  localparam logic signed [COORD_BIT:0] GH   = (COORD_BIT+1)'(GRID_H);
  localparam logic [SNAKE_LENGTH_BIT-1:0] MAX_L = SNAKE_LENGTH_BIT'(MAX_LENGTH);

  state_t state, state_next;

  logic [COORD_BIT-1:0]        seg_x [MAX_LENGTH];
  logic [COORD_BIT-1:0]        seg_y [MAX_LENGTH];
  logic [SNAKE_LENGTH_BIT-1:0] length;
  logic [SNAKE_LENGTH_BIT-1:0] k;
  logic [1:0]                  heading;
  logic                        grow_pending;
  logic [COORD_BIT-1:0]        new_x, new_y;

  logic                        tik_ok;
  logic [1:0]                  heading_next;
  logic signed [COORD_BIT:0]   cand_x, cand_y;
  logic                        off_grid;
  logic [COORD_BIT-1:0]        wrap_x, wrap_y;
  logic [COORD_BIT-1:0]        seg_k_x, seg_k_y;
  logic [COORD_BIT-1:0]        rd_sel_x, rd_sel_y;

  // Heading selection and candidate head position for an accepted tik.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    tik_ok       = (state == IDLE) && game_tik;
    heading_next = heading;
    // Reversing onto the neck is refused once there is a body behind the head.
    if (tik_ok && !((dir[1] == heading[1]) && (dir[0] != heading[0]) && (length > 1)))
      heading_next = dir;
    cand_x = $signed({1'b0, seg_x[0]});
    cand_y = $signed({1'b0, seg_y[0]});
    case (heading_next)
      RIGHT:   cand_x = cand_x + ONE;
      LEFT:    cand_x = cand_x - ONE;
      UP:      cand_y = cand_y - ONE;
      default: cand_y = cand_y + ONE;
    endcase
    off_grid = (cand_x < 0) || (cand_x >= GW) || (cand_y < 0) || (cand_y >= GH);
    if (cand_x < 0)        wrap_x = COORD_BIT'(GW - ONE);
    else if (cand_x >= GW) wrap_x = '0;
    else                   wrap_x = cand_x[COORD_BIT-1:0];
    if (cand_y < 0)        wrap_y = COORD_BIT'(GH - ONE);
    else if (cand_y >= GH) wrap_y = '0;
    else                   wrap_y = cand_y[COORD_BIT-1:0];
  end

  // Segment muxes: the one under collision test and the one being read out.
  always_comb begin
    seg_k_x  = '0;
    seg_k_y  = '0;
    rd_sel_x = '0;
    rd_sel_y = '0;
    for (int i = 0; i < MAX_LENGTH; i++) begin
      if (k == SNAKE_LENGTH_BIT'(i)) begin
        seg_k_x = seg_x[i];
        seg_k_y = seg_y[i];
      end
      if (rd_index == SNAKE_LENGTH_BIT'(i)) begin
        rd_sel_x = seg_x[i];
        rd_sel_y = seg_y[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clock_25 or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; restart overrides everything.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (tik_ok) state_next = (off_grid && (WRAP == 0)) ? DEAD : SHIFT;
      SHIFT: state_next = CHECK;
      CHECK: begin
        if (k >= length)                                      state_next = DONE;
        else if ((seg_k_x == seg_x[0]) && (seg_k_y == seg_y[0])) state_next = DEAD;
      end
      DONE:    state_next = IDLE;
      default: state_next = DEAD;
    endcase
    if (restart) state_next = IDLE;
  end

  // Outputs decoded from state.
  always_comb begin
    busy               = (state == SHIFT) || (state == CHECK) || (state == DONE);
    move_done          = (state == DONE);
    collision_detected = (state == DEAD);
  end

  // Segment store, length, heading, growth, scan index and registered read port.
  always_ff @(posedge clock_25 or negedge reset) begin
    // NOTE: the segment array is reset explicitly: it is a visible register file, not RAM.
    if (!reset) begin
      for (int i = 0; i < MAX_LENGTH; i++) begin
        seg_x[i] <= (i < START_LEN) ? COORD_BIT'(START_X - i) : '0;
        seg_y[i] <= (i < START_LEN) ? COORD_BIT'(START_Y) : '0;
      end
      length       <= SNAKE_LENGTH_BIT'(START_LEN);
      k            <= '0;
      heading      <= RIGHT;
      grow_pending <= 1'b0;
      new_x        <= '0;
      new_y        <= '0;
      rd_x         <= '0;
      rd_y         <= '0;
      rd_valid     <= 1'b0;
    end else if (restart) begin
      for (int i = 0; i < MAX_LENGTH; i++) begin
        seg_x[i] <= (i < START_LEN) ? COORD_BIT'(START_X - i) : '0;
        seg_y[i] <= (i < START_LEN) ? COORD_BIT'(START_Y) : '0;
      end
      length       <= SNAKE_LENGTH_BIT'(START_LEN);
      k            <= '0;
      heading      <= RIGHT;
      grow_pending <= 1'b0;
      new_x        <= '0;
      new_y        <= '0;
      rd_x         <= '0;
      rd_y         <= '0;
      rd_valid     <= 1'b0;
    end else begin
      if (tik_ok) begin
        heading <= heading_next;
        new_x   <= wrap_x;
        new_y   <= wrap_y;
      end
      if (state == SHIFT) begin
        for (int i = MAX_LENGTH - 1; i > 0; i--) begin
          seg_x[i] <= seg_x[i-1];
          seg_y[i] <= seg_y[i-1];
        end
        seg_x[0] <= new_x;
        seg_y[0] <= new_y;
        if (grow_pending && (length < MAX_L)) length <= length + 1'b1;
        // A grow arriving during the shift is held for the following move.
        grow_pending <= grow;
        k            <= SNAKE_LENGTH_BIT'(1);
      end else if (grow && (state != DEAD)) begin
        grow_pending <= 1'b1;
      end
      if ((state == CHECK) && (k < length)) k <= k + 1'b1;
      rd_x     <= rd_sel_x;
      rd_y     <= rd_sel_y;
      rd_valid <= (rd_index < length);
    end
  end

  assign snake_head_x = seg_x[0];
  assign snake_head_y = seg_y[0];
  assign snake_length = length;

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine. Two instances share all stimulus:
// one kills on wall contact, the other wraps. A behavioural snake model
// predicts positions; expected values go into a scoreboard queue when the
// stimulus is driven and are compared when the DUT responds.
module tb_snake_body_engine;

  localparam int CB = 7;
  localparam int LB = 4;
  localparam int ML = 15;

  logic          clock_25 = 1'b0;
  logic          reset    = 1'b0;
  logic          game_tik = 1'b0;
  logic [1:0]    dir      = 2'b00;
  logic          grow     = 1'b0;
  logic          restart  = 1'b0;
  logic [LB-1:0] rd_index = '0;

  logic [CB-1:0] a_rd_x, a_rd_y, a_head_x, a_head_y;
  logic [LB-1:0] a_length;
  logic          a_rd_valid, a_busy, a_move_done, a_collision;
  logic [CB-1:0] w_rd_x, w_rd_y, w_head_x, w_head_y;
  logic [LB-1:0] w_length;
  logic          w_rd_valid, w_busy, w_move_done, w_collision;

  snake_body_engine #(.WRAP(0)) dut (
    .clock_25(clock_25), .reset(reset), .game_tik(game_tik), .dir(dir),
    .grow(grow), .restart(restart), .rd_index(rd_index),
    .rd_x(a_rd_x), .rd_y(a_rd_y), .rd_valid(a_rd_valid),
    .snake_head_x(a_head_x), .snake_head_y(a_head_y), .snake_length(a_length),
    .busy(a_busy), .move_done(a_move_done), .collision_detected(a_collision)
  );

  snake_body_engine #(.WRAP(1)) dut_w (
    .clock_25(clock_25), .reset(reset), .game_tik(game_tik), .dir(dir),
    .grow(grow), .restart(restart), .rd_index(rd_index),
    .rd_x(w_rd_x), .rd_y(w_rd_y), .rd_valid(w_rd_valid),
    .snake_head_x(w_head_x), .snake_head_y(w_head_y), .snake_length(w_length),
    .busy(w_busy), .move_done(w_move_done), .collision_detected(w_collision)
  );

  always #5 clock_25 = ~clock_25;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  // Snake model: positions, length, heading (up decreases y).
  int mx [ML];
  int my [ML];
  int mlen;
  int mhead;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ML; i++) begin
      mx[i] = (i < 3) ? 10 - i : 0;
      my[i] = (i < 3) ? 10 : 0;
    end
    mlen  = 3;
    mhead = 0;
  endtask

  task automatic model_move(input int d, input bit g);
    int nx, ny;
    if (!((d / 2 == mhead / 2) && (d != mhead) && (mlen > 1))) mhead = d;
    nx = mx[0];
    ny = my[0];
    case (mhead)
      0: nx = nx + 1;
      1: nx = nx - 1;
      2: ny = ny - 1;
      default: ny = ny + 1;
    endcase
    for (int i = ML - 1; i > 0; i--) begin
      mx[i] = mx[i-1];
      my[i] = my[i-1];
    end
    mx[0] = nx;
    my[0] = ny;
    if (g && mlen < ML) mlen++;
  endtask

  // Registered read: expectations queued with the index, checked a cycle later.
  task automatic read_seg(input int idx);
    @(negedge clock_25);
    rd_index = LB'(idx);
    push($sformatf("rd_x[%0d]", idx), mx[idx]);
    push($sformatf("rd_y[%0d]", idx), my[idx]);
    push($sformatf("rd_valid[%0d]", idx), (idx < mlen) ? 1 : 0);
    @(posedge clock_25);
    #1;
    pop_check(a_rd_x);
    pop_check(a_rd_y);
    pop_check(a_rd_valid);
  endtask

  task automatic pulse_grow();
    @(negedge clock_25);
    grow = 1'b1;
    @(negedge clock_25);
    grow = 1'b0;
  endtask

  // One move: latency from the sampling edge of game_tik to move_done, then head/length.
  task automatic move(input int d, input bit g);
    int cnt;
    @(negedge clock_25);
    dir      = 2'(d);
    game_tik = 1'b1;
    model_move(d, g);
    push("move_latency", mlen + 2);
    push("head_x", mx[0]);
    push("head_y", my[0]);
    push("length", mlen);
    cnt = 0;
    do begin
      @(posedge clock_25);
      cnt++;
      #1;
      game_tik = 1'b0;
    end while (!a_move_done && cnt < 40);
    pop_check(cnt);
    pop_check(a_head_x);
    pop_check(a_head_y);
    pop_check(a_length);
    @(posedge clock_25);
    #1;
  endtask

  task automatic do_restart();
    @(negedge clock_25);
    restart = 1'b1;
    @(posedge clock_25);
    #1;
    restart = 1'b0;
    model_reset();
    check("restart_head_x", a_head_x, 10);
    check("restart_head_y", a_head_y, 10);
    check("restart_length", a_length, 3);
    check("restart_collision", a_collision, 0);
    check("restart_busy", a_busy, 0);
    check("restart_rd_valid", a_rd_valid, 0);
    check("restart_w_head_x", w_head_x, 10);
  endtask

  initial begin
    int  cnt;
    bit  seen;
    int  pulses;

    model_reset();

    // Reset state, sampled while reset is held.
    #12;
    check("reset_head_x", a_head_x, 10);
    check("reset_head_y", a_head_y, 10);
    check("reset_length", a_length, 3);
    check("reset_busy", a_busy, 0);
    check("reset_move_done", a_move_done, 0);
    check("reset_collision", a_collision, 0);
    check("reset_rd_valid", a_rd_valid, 0);
    @(negedge clock_25);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) read_seg(i);

    // Plain move right, then a refused reversal.
    move(0, 1'b0);
    read_seg(2);
    move(1, 1'b0);
    check("reverse_head_x", a_head_x, 12);

    // Grow then move: length 4, tail retained.
    pulse_grow();
    move(0, 1'b1);
    for (int i = 0; i < 5; i++) read_seg(i);

    // Second tik during busy is dropped.
    @(negedge clock_25);
    dir      = 2'b00;
    game_tik = 1'b1;
    model_move(0, 1'b0);
    @(negedge clock_25);
    game_tik = 1'b0;
    @(negedge clock_25);
    game_tik = 1'b1;
    @(negedge clock_25);
    game_tik = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clock_25);
      #1;
      if (a_move_done) pulses++;
    end
    check("busy_tik_pulses", pulses, 1);
    check("busy_tik_head_x", a_head_x, mx[0]);

    // March to the right wall.
    while (mx[0] < 63) move(0, 1'b0);
    check("at_wall_head_x", a_head_x, 63);

    // Wall hit: kill instance dies in place, wrap instance comes out at x=0.
    @(negedge clock_25);
    dir      = 2'b00;
    game_tik = 1'b1;
    seen = 1'b0;
    cnt  = 0;
    do begin
      @(posedge clock_25);
      cnt++;
      #1;
      game_tik = 1'b0;
      if (w_move_done) seen = 1'b1;
    end while (!seen && cnt < 40);
    check("wrap_move_done", seen, 1);
    check("wrap_head_x", w_head_x, 0);
    check("wrap_head_y", w_head_y, 10);
    check("wall_collision", a_collision, 1);
    check("wall_head_x", a_head_x, 63);
    check("wall_busy", a_busy, 0);

    // Dead ignores further tiks and grows.
    pulse_grow();
    @(negedge clock_25);
    game_tik = 1'b1;
    dir      = 2'b01;
    @(negedge clock_25);
    game_tik = 1'b0;
    repeat (20) @(posedge clock_25);
    #1;
    check("dead_head_x", a_head_x, 63);
    check("dead_length", a_length, mlen);
    check("dead_collision", a_collision, 1);

    do_restart();
    for (int i = 0; i < 4; i++) read_seg(i);

    // Self-collision: grow to 5, then up, left, down into the body.
    pulse_grow();
    move(0, 1'b1);
    pulse_grow();
    move(0, 1'b1);
    move(2, 1'b0);
    move(1, 1'b0);
    @(negedge clock_25);
    dir      = 2'b11;
    game_tik = 1'b1;
    seen   = 1'b0;
    pulses = 0;
    cnt    = 0;
    do begin
      @(posedge clock_25);
      cnt++;
      #1;
      game_tik = 1'b0;
      if (a_move_done) pulses++;
      if (a_collision) seen = 1'b1;
    end while (!seen && cnt < 40);
    check("self_collision", seen, 1);
    check("self_collision_no_done", pulses, 0);
    check("self_collision_head_x", a_head_x, 11);
    check("self_collision_head_y", a_head_y, 10);
    check("self_collision_w", w_collision, 1);

    do_restart();

    // Grow up to the cap and one beyond.
    for (int n = 0; n < 13; n++) begin
      pulse_grow();
      move(0, 1'b1);
    end
    check("max_length", a_length, 15);
    read_seg(14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_body_engine.md
Name: snake_body_engine

Overview:
- Parametrised snake position store and move engine: keeps head plus up to MAX_LENGTH-1 body segments in a register array.
- On each game_tik it advances the head, shifts the body, optionally grows, then scans the body serially for self-collision.
- Wall handling is selectable: kill or wrap-around.
- Sits between game-tick/direction logic and the graphic path; the renderer reads segments through a registered read port.

Parameters:
- COORD_BIT, 7, width of x/y grid coordinates.
- SNAKE_LENGTH_BIT, 4, width of length and index signals.
- MAX_LENGTH, 15, maximum segments including head (≤ 2^SNAKE_LENGTH_BIT - 1).
- GRID_W, 64, grid columns; legal x is 0..GRID_W-1.
- GRID_H, 48, grid rows; legal y is 0..GRID_H-1.
- START_X, 10, head x after reset or restart.
- START_Y, 10, head y after reset or restart.
- START_LEN, 3, length after reset or restart (≥1, ≤MAX_LENGTH, < START_X+1).
- WRAP, 0, wall mode: 0 = wall collision kills; 1 = coordinates wrap modulo grid.

Ports:
- clock_25  input  1  system clock.
- reset  input  1  asynchronous active-low reset.
- game_tik  input  1  one-cycle move strobe.
- dir  input  2  requested heading: 00 right, 01 left, 10 up, 11 down.
- grow  input  1  one-cycle pulse: fruit eaten.
- restart  input  1  synchronous re-initialise.
- rd_index  input  SNAKE_LENGTH_BIT  segment to read; 0 = head.
- rd_x  output  COORD_BIT  x of segment rd_index, registered.
- rd_y  output  COORD_BIT  y of segment rd_index, registered.
- rd_valid  output  1  registered (rd_index < snake_length).
- snake_head_x  output  COORD_BIT  segment 0 x.
- snake_head_y  output  COORD_BIT  segment 0 y.
- snake_length  output  SNAKE_LENGTH_BIT  current length.
- busy  output  1  high when the FSM is not in IDLE or DEAD.
- move_done  output  1  one-cycle pulse when a move completes without collision.
- collision_detected  output  1  sticky; high in DEAD.

Behaviour:
- Reset (reset=0, async): state IDLE; head=(START_X,START_Y); segment i=(START_X-i, START_Y) for i<START_LEN, unused segments 0; length=START_LEN; heading=right; grow_pending=0; rd_x/rd_y/rd_valid/move_done/collision_detected/busy=0.
- restart=1 at a clock edge: same values as reset, from any state. restart has priority over every other input.
- Heading update:
  - Taken only on an accepted game_tik.
  - If dir is the opposite of the current heading and length>1, the current heading is kept.
  - Otherwise heading=dir.
- grow_pending:
  - Set by grow in any state except DEAD.
  - Cleared in SHIFT when consumed.
  - grow in the same cycle as SHIFT is kept for the next move.
- IDLE:
  - game_tik=1 computes the new head from the new heading.
  - WRAP=0 and the head would leave the grid (x<0, x≥GRID_W, y<0, y≥GRID_H): go to DEAD; nothing shifts.
  - WRAP=1: x=-1→GRID_W-1, x=GRID_W→0, same rule for y. Go to SHIFT.
- SHIFT (1 cycle):
  - seg[i]<=seg[i-1] for i=1..MAX_LENGTH-1; seg[0]<=new head.
  - If grow_pending and length<MAX_LENGTH: length+1. At MAX_LENGTH, grow is consumed and ignored.
  - k<=1. Next state CHECK.
- CHECK (one compare per cycle):
  - If k≥length: go to DONE.
  - Else if seg[k]==seg[0]: go to DEAD.
  - Else k+1.
  - Move latency (tik → move_done) = length+2 cycles.
- DONE: move_done=1 for one cycle, then IDLE.
- DEAD: collision_detected=1; all game_tik and grow are ignored; only restart or reset leaves this state.
- game_tik while busy: ignored, no queueing.
- Read port:
  - rd_x/rd_y/rd_valid update 1 cycle after rd_index, every cycle, in every state.
  - During SHIFT the read returns the pre-shift value.
- Width: head arithmetic uses COORD_BIT+1 signed intermediates; no silent truncation of -1.

Test Plan:
- Reset release, defaults → head (10,10); rd_index=1,2 give (9,10),(8,10); length=3; rd_index=3 gives rd_valid=0.
- game_tik with dir=00 → head (11,10); move_done exactly 5 cycles after tik; segment 2 = (9,10).
- grow pulse, then game_tik → length=4; new tail (8,10). With MAX_LENGTH reached, a further grow leaves length=15.
- dir=01 (reverse) at length 3 → head still moves right to (12,10).
- WRAP=0, head at (63,y), dir=00 tik → collision_detected=1, head unchanged; later tiks ignored. With WRAP=1 the head goes to (0,y) and move_done pulses.
- Length 5, sequence up, left, down into own body → collision_detected=1 during CHECK. restart → state as after reset; second game_tik during busy → no extra move.
